// File: rtl/test_image_timing_ctrl_if.sv
// rtl/test_image_timing_ctrl_if.sv - signal bundle between frame-timing controller and its environment
//
// Purpose: groups sensor timing, stream control, geometry config, pattern
// select and the generated frame/line timing into one interface.
//   master : drives stream enable, source select, sensor fval/lval, config, pattern request
//   slave  : drives o_fval, o_lval, ov_test_image_sel, o_frame_done, ov_frame_cnt
interface test_image_timing_ctrl_if #(
   parameter int CNT_WIDTH       = 16,
   parameter int FRAME_CNT_WIDTH = 16
);
   logic                       i_stream_en;
   logic                       i_src_sel;
   logic                       i_fval;
   logic                       i_lval;
   logic [CNT_WIDTH-1:0]       iv_line_width;
   logic [CNT_WIDTH-1:0]       iv_line_num;
   logic [CNT_WIDTH-1:0]       iv_hblank;
   logic [CNT_WIDTH-1:0]       iv_vfront;
   logic [CNT_WIDTH-1:0]       iv_vback;
   logic [CNT_WIDTH-1:0]       iv_frame_gap;
   logic [2:0]                 iv_test_image_sel_req;
   logic                       o_fval;
   logic                       o_lval;
   logic [2:0]                 ov_test_image_sel;
   logic                       o_frame_done;
   logic [FRAME_CNT_WIDTH-1:0] ov_frame_cnt;

   modport master (
      output i_stream_en, i_src_sel, i_fval, i_lval,
      output iv_line_width, iv_line_num, iv_hblank, iv_vfront, iv_vback, iv_frame_gap,
      output iv_test_image_sel_req,
      input  o_fval, o_lval, ov_test_image_sel, o_frame_done, ov_frame_cnt
   );

   modport slave (
      input  i_stream_en, i_src_sel, i_fval, i_lval,
      input  iv_line_width, iv_line_num, iv_hblank, iv_vfront, iv_vback, iv_frame_gap,
      input  iv_test_image_sel_req,
      output o_fval, o_lval, ov_test_image_sel, o_frame_done, ov_frame_cnt
   );
endinterface

// File: rtl/test_image_timing_ctrl.sv
// rtl/test_image_timing_ctrl.sv - frame-timing controller and pattern scheduler for the test-image generator
//
// Purpose: produces frame/line valid either by gating the sensor timing or from
// an internal programmable generator; latches geometry and pattern select only
// at frame start; starts/stops streaming on whole frames; counts completed frames.
// Ports:
//   clk   : pixel clock, rising edge
//   reset : asynchronous, active-high, clears all state and outputs
//   tif   : slave side of test_image_timing_ctrl_if (stream control, sensor
//           timing, config in; o_fval/o_lval/pattern select/frame done/count out)
module test_image_timing_ctrl #(
   parameter int CNT_WIDTH       = 16,
   parameter int FRAME_CNT_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   test_image_timing_ctrl_if.slave tif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_VFRONT,
      S_LINE,
      S_HBLANK,
      S_VBACK,
      S_GAP,
      S_EXT_FRAME
   } state_t;

   localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

   state_t               state;
   logic [CNT_WIDTH-1:0] cnt;        // cycles remaining in current phase, minus one
   logic [CNT_WIDTH-1:0] line_cnt;   // lines still to be emitted, including current
   logic [CNT_WIDTH-1:0] sh_line_width;
   logic [CNT_WIDTH-1:0] sh_hblank;
   logic [CNT_WIDTH-1:0] sh_vback;
   logic [CNT_WIDTH-1:0] sh_frame_gap;
   logic                 fval_prev;

   // A zero-length field would underflow the down-counters; treat it as one cycle.
   function automatic logic [CNT_WIDTH-1:0] nz(input logic [CNT_WIDTH-1:0] v);
      return (v == '0) ? ONE : v;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state                 <= S_IDLE;
         cnt                   <= '0;
         line_cnt              <= '0;
         sh_line_width         <= ONE;
         sh_hblank             <= ONE;
         sh_vback              <= ONE;
         sh_frame_gap          <= ONE;
         // Starts high so a sensor frame already running at reset release is not taken as a rise.
         fval_prev             <= 1'b1;
         tif.o_fval            <= 1'b0;
         tif.o_lval            <= 1'b0;
         tif.ov_test_image_sel <= 3'b000;
         tif.o_frame_done      <= 1'b0;
         tif.ov_frame_cnt      <= '0;
      end else begin
         fval_prev        <= tif.i_fval;
         tif.o_frame_done <= 1'b0;
         case (state)
            S_IDLE: begin
               tif.o_fval <= 1'b0;
               tif.o_lval <= 1'b0;
               if (tif.i_stream_en && (tif.i_src_sel || (tif.i_fval && !fval_prev))) begin
                  sh_line_width         <= nz(tif.iv_line_width);
                  sh_hblank             <= nz(tif.iv_hblank);
                  sh_vback              <= nz(tif.iv_vback);
                  sh_frame_gap          <= nz(tif.iv_frame_gap);
                  tif.ov_test_image_sel <= tif.iv_test_image_sel_req;
                  tif.o_fval            <= 1'b1;
                  if (tif.i_src_sel) begin
                     state    <= S_VFRONT;
                     cnt      <= nz(tif.iv_vfront) - ONE;
                     line_cnt <= nz(tif.iv_line_num);
                  end else begin
                     state      <= S_EXT_FRAME;
                     tif.o_lval <= tif.i_lval;
                  end
               end
            end
            S_VFRONT: begin
               if (cnt == '0) begin
                  state      <= S_LINE;
                  cnt        <= sh_line_width - ONE;
                  tif.o_lval <= 1'b1;
               end else begin
                  cnt <= cnt - ONE;
               end
            end
            S_LINE: begin
               if (cnt == '0) begin
                  line_cnt   <= line_cnt - ONE;
                  tif.o_lval <= 1'b0;
                  if (line_cnt == ONE) begin
                     state <= S_VBACK;
                     cnt   <= sh_vback - ONE;
                  end else begin
                     state <= S_HBLANK;
                     cnt   <= sh_hblank - ONE;
                  end
               end else begin
                  cnt <= cnt - ONE;
               end
            end
            S_HBLANK: begin
               if (cnt == '0) begin
                  state      <= S_LINE;
                  cnt        <= sh_line_width - ONE;
                  tif.o_lval <= 1'b1;
               end else begin
                  cnt <= cnt - ONE;
               end
            end
            S_VBACK: begin
               if (cnt == '0) begin
                  state            <= S_GAP;
                  cnt              <= sh_frame_gap - ONE;
                  tif.o_fval       <= 1'b0;
                  tif.o_frame_done <= 1'b1;
                  tif.ov_frame_cnt <= tif.ov_frame_cnt + FRAME_CNT_WIDTH'(1);
               end else begin
                  cnt <= cnt - ONE;
               end
            end
            S_GAP: begin
               if (cnt == '0) begin
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt - ONE;
               end
            end
            S_EXT_FRAME: begin
               // o_fval is always 1 while here, so a low sample is the falling edge.
               tif.o_fval <= tif.i_fval;
               tif.o_lval <= tif.i_fval & tif.i_lval;
               if (!tif.i_fval) begin
                  state            <= S_IDLE;
                  tif.o_frame_done <= 1'b1;
                  tif.ov_frame_cnt <= tif.ov_frame_cnt + FRAME_CNT_WIDTH'(1);
               end
            end
            default: begin
               state      <= S_IDLE;
               tif.o_fval <= 1'b0;
               tif.o_lval <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_test_image_timing_ctrl.sv
// tb/tb_test_image_timing_ctrl.sv - self-checking bench for test_image_timing_ctrl
module tb_test_image_timing_ctrl;
   localparam int CW = 16;
   localparam int FW = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   test_image_timing_ctrl_if #(.CNT_WIDTH(CW), .FRAME_CNT_WIDTH(FW)) tif ();

   test_image_timing_ctrl #(.CNT_WIDTH(CW), .FRAME_CNT_WIDTH(FW)) dut (
      .clk   (clk),
      .reset (reset),
      .tif   (tif)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: frame described by its start and geometry, outputs derived
   // from the offset within the frame.
   int         m_mode;   // 0 idle, 1 internal frame, 2 sensor frame
   int         m_j, m_v, m_w, m_h, m_n, m_b, m_g, m_len;
   int         m_cnt;
   logic [2:0] m_sel;
   logic       m_prev;
   logic       exp_fval, exp_lval, exp_done;

   function automatic int nz(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   function automatic logic in_line(input int j);
      int m;
      m = j - m_v;
      return (m >= 0) && (m < m_n * m_w + (m_n - 1) * m_h) && ((m % (m_w + m_h)) < m_w);
   endfunction

   task automatic model_reset();
      m_mode = 0; m_cnt = 0; m_sel = 3'b000; m_prev = 1'b1;
      exp_fval = 0; exp_lval = 0; exp_done = 0;
   endtask

   task automatic model_step();
      exp_done = 1'b0;
      if (m_mode == 0) begin
         exp_fval = 1'b0;
         exp_lval = 1'b0;
         if (tif.i_stream_en && tif.i_src_sel) begin
            m_v = nz(int'(tif.iv_vfront));  m_w = nz(int'(tif.iv_line_width));
            m_h = nz(int'(tif.iv_hblank));  m_n = nz(int'(tif.iv_line_num));
            m_b = nz(int'(tif.iv_vback));   m_g = nz(int'(tif.iv_frame_gap));
            m_len = m_v + m_n * m_w + (m_n - 1) * m_h + m_b;
            m_sel = tif.iv_test_image_sel_req;
            m_mode = 1; m_j = 0;
         end else if (tif.i_stream_en && !tif.i_src_sel && tif.i_fval && !m_prev) begin
            m_sel = tif.iv_test_image_sel_req;
            m_mode = 2;
         end
      end else if (m_mode == 1) begin
         m_j++;
      end
      if (m_mode == 1) begin
         if (m_j < m_len) begin
            exp_fval = 1'b1;
            exp_lval = in_line(m_j);
         end else begin
            exp_fval = 1'b0;
            exp_lval = 1'b0;
            if (m_j == m_len) begin
               exp_done = 1'b1;
               m_cnt = (m_cnt + 1) % (1 << FW);
            end
            if (m_j == m_len + m_g) m_mode = 0;
         end
      end else if (m_mode == 2) begin
         exp_fval = tif.i_fval;
         exp_lval = tif.i_fval & tif.i_lval;
         if (!tif.i_fval) begin
            exp_done = 1'b1;
            m_cnt = (m_cnt + 1) % (1 << FW);
            m_mode = 0;
         end
      end
      m_prev = tif.i_fval;
   endtask

   // Run-length bookkeeping for the directed geometry checks.
   logic last_fval = 1'b0;
   int   hi_run = 0, lo_run = 0, exp_hi = 0, exp_lo = 0;
   logic chk_runs = 1'b0, lo_valid = 1'b0;

   task automatic step_cycle();
      @(posedge clk);
      model_step();
      #1;
      check_eq("o_fval", 32'(tif.o_fval), 32'(exp_fval));
      check_eq("o_lval", 32'(tif.o_lval), 32'(exp_lval));
      check_eq("o_frame_done", 32'(tif.o_frame_done), 32'(exp_done));
      check_eq("ov_test_image_sel", 32'(tif.ov_test_image_sel), 32'(m_sel));
      check_eq("ov_frame_cnt", 32'(tif.ov_frame_cnt), 32'(m_cnt));
      if (tif.o_fval) begin
         if (!last_fval) begin
            if (chk_runs && lo_valid) check_eq("fval_low_len", 32'(lo_run), 32'(exp_lo));
            hi_run = 0;
         end
         hi_run++;
      end else begin
         if (last_fval) begin
            if (chk_runs) check_eq("fval_high_len", 32'(hi_run), 32'(exp_hi));
            lo_valid = 1'b1;
            lo_run = 0;
         end
         lo_run++;
      end
      last_fval = tif.o_fval;
   endtask

   task automatic set_cfg(input int w, input int n, input int h, input int vf, input int vb, input int g);
      tif.iv_line_width = CW'(w); tif.iv_line_num = CW'(n); tif.iv_hblank = CW'(h);
      tif.iv_vfront = CW'(vf);    tif.iv_vback = CW'(vb);   tif.iv_frame_gap = CW'(g);
   endtask

   logic [15:0] seq_fval, seq_lval;
   logic        found;

   initial begin
      reset = 1'b1;
      tif.i_stream_en = 0; tif.i_src_sel = 0; tif.i_fval = 0; tif.i_lval = 0;
      tif.iv_test_image_sel_req = 3'b000;
      set_cfg(0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_fval", 32'(tif.o_fval), 0);
      check_eq("rst_lval", 32'(tif.o_lval), 0);
      check_eq("rst_sel", 32'(tif.ov_test_image_sel), 0);
      check_eq("rst_done", 32'(tif.o_frame_done), 0);
      check_eq("rst_cnt", 32'(tif.ov_frame_cnt), 0);
      reset = 1'b0;

      // Internal geometry, pattern change mid-frame, stop during HBLANK of frame 3.
      set_cfg(4, 3, 2, 1, 2, 3);
      tif.i_src_sel = 1; tif.i_stream_en = 1;
      exp_hi = 19; exp_lo = 4; chk_runs = 1; lo_valid = 0;
      for (int c = 0; c < 75; c++) begin
         step_cycle();
         if (c == 8)  tif.iv_test_image_sel_req = 3'b010;
         if (c == 52) tif.i_stream_en = 0;
      end
      check_eq("frames_after_stop", 32'(tif.ov_frame_cnt), 3);
      check_eq("sel_after_change", 32'(tif.ov_test_image_sel), 32'(3'b010));

      // Zero config: every field acts as one.
      set_cfg(0, 0, 0, 0, 0, 0);
      exp_hi = 3; exp_lo = 2; lo_valid = 0;
      tif.i_stream_en = 1;
      for (int c = 0; c < 12; c++) step_cycle();
      tif.i_stream_en = 0;
      for (int c = 0; c < 8; c++) step_cycle();
      chk_runs = 0;

      // Sensor mode: frame in progress when enabled is dropped, next is reproduced.
      tif.i_src_sel = 0;
      tif.i_fval = 1;
      step_cycle();
      tif.i_stream_en = 1;
      seq_fval = 16'b0011_1111_1000_1111;
      seq_lval = 16'b0010_1101_1001_0110;
      for (int c = 0; c < 16; c++) begin
         tif.i_fval = seq_fval[c];
         tif.i_lval = seq_lval[c];
         step_cycle();
      end
      tif.i_fval = 0; tif.i_lval = 0;
      for (int c = 0; c < 4; c++) step_cycle();

      // Randomized mix of modes, config and pattern changes, enable toggling.
      for (int c = 0; c < 4000; c++) begin
         step_cycle();
         if ($urandom_range(0, 15) == 0) tif.i_stream_en = ~tif.i_stream_en;
         if ($urandom_range(0, 31) == 0) tif.i_src_sel = ~tif.i_src_sel;
         if ($urandom_range(0, 3) == 0)  tif.iv_test_image_sel_req = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 31) == 0)
            set_cfg($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
         if ($urandom_range(0, 5) == 0) tif.i_fval = ~tif.i_fval;
         tif.i_lval = 1'($urandom_range(0, 1));
      end

      // Reset asserted during LINE, then a clean frame after release.
      set_cfg(4, 3, 2, 1, 2, 3);
      tif.i_src_sel = 1; tif.i_stream_en = 1; tif.iv_test_image_sel_req = 3'b101;
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         step_cycle();
         if (m_mode == 1 && exp_lval) found = 1'b1;
      end
      check_eq("reach_line", 32'(found), 1);
      reset = 1'b1;
      #1;
      check_eq("arst_fval", 32'(tif.o_fval), 0);
      check_eq("arst_lval", 32'(tif.o_lval), 0);
      check_eq("arst_cnt", 32'(tif.ov_frame_cnt), 0);
      check_eq("arst_sel", 32'(tif.ov_test_image_sel), 0);
      check_eq("arst_done", 32'(tif.o_frame_done), 0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      last_fval = 1'b0;
      for (int c = 0; c < 30; c++) step_cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/test_image_timing_ctrl.md
# test_image_timing_ctrl

Frame-timing controller and pattern scheduler that sits in front of the test-image generator. It sources the frame/line valid timing either from the sensor (gated pass-through) or from an internal programmable timing generator. It latches the pattern select and timing configuration only at frame start, so a pattern or geometry change never takes effect mid-frame. It also starts and stops streaming on whole-frame boundaries and counts completed frames.

## Interface
Parameters:
- CNT_WIDTH, 16, width of every timing/geometry config field and internal counter
- FRAME_CNT_WIDTH, 16, width of completed-frame counter

Ports:
- clk  input  1  pixel clock; every register is clocked on its rising edge
- reset  input  1  asynchronous, active-high; clears all state and outputs immediately
- i_stream_en  input  1  streaming enable; sampled only at frame start
- i_src_sel  input  1  0 = sensor timing pass-through, 1 = internal generator; latched at frame start
- i_fval  input  1  sensor frame valid
- i_lval  input  1  sensor line valid
- iv_line_width  input  CNT_WIDTH  active clocks per line (internal mode)
- iv_line_num  input  CNT_WIDTH  lines per frame (internal mode)
- iv_hblank  input  CNT_WIDTH  lval-low clocks between lines
- iv_vfront  input  CNT_WIDTH  clocks from fval rise to first lval
- iv_vback  input  CNT_WIDTH  clocks from last lval fall to fval fall
- iv_frame_gap  input  CNT_WIDTH  fval-low clocks in GAP state
- iv_test_image_sel_req  input  3  requested pattern select
- o_fval  output  1  frame valid to test-image generator
- o_lval  output  1  line valid to test-image generator
- ov_test_image_sel  output  3  pattern select, stable for the whole frame
- o_frame_done  output  1  one-cycle pulse on the cycle o_fval goes 1→0
- ov_frame_cnt  output  FRAME_CNT_WIDTH  completed frames, wraps to 0

## Operation
- States: IDLE, VFRONT, LINE, HBLANK, VBACK, GAP (internal mode); EXT_FRAME (sensor mode).
- Every config field equal to 0 is treated as 1.
- Shadow registers hold the config fields, i_src_sel and the pattern select. They load only on a frame-start transition (IDLE→VFRONT or IDLE→EXT_FRAME). ov_test_image_sel is driven from its shadow register.
- IDLE:
  - If i_stream_en=1 and i_src_sel=1: load shadows, go to VFRONT.
  - If i_stream_en=1 and i_src_sel=0 and a sensor fval rise is seen (i_fval=1 with the previous i_fval=0): load shadows, go to EXT_FRAME.
  - Otherwise stay in IDLE.
- VFRONT lasts vfront cycles, then LINE.
- LINE lasts line_width cycles. After the last line go to VBACK; otherwise go to HBLANK for hblank cycles, then back to LINE.
- Line counter: loads line_num at frame start and decrements at each LINE exit.
- VBACK lasts vback cycles, then GAP.
- GAP lasts frame_gap cycles, then IDLE. A new frame therefore sees fval low for frame_gap+1 cycles.
- o_fval, o_lval and ov_test_image_sel are registered:
  - Internal mode: o_fval=1 in VFRONT/LINE/HBLANK/VBACK; o_lval=1 in LINE only.
  - EXT_FRAME: o_fval = i_fval and o_lval = i_fval & i_lval, each delayed one clock. When i_fval=0 is sampled, go to IDLE.
- Sensor frame already in progress when IDLE is entered or reset is released, with no rise observed: dropped, outputs stay 0.
- i_stream_en deasserted mid-frame: the frame completes normally, then the block stays in IDLE.
- i_src_sel or config changes mid-frame: ignored until the next frame start.
- o_frame_done: asserted when o_fval is registered 1→0. ov_frame_cnt increments on the same edge and wraps from all-ones to 0.

## Timing
- Reset values: o_fval=0, o_lval=0, ov_test_image_sel=3'b000, o_frame_done=0, ov_frame_cnt=0, state=IDLE.
- Reset mid-frame drops o_fval/o_lval asynchronously, with no o_frame_done.
- Internal mode: o_fval rises one clock after the IDLE cycle that sees i_stream_en=1.
- Internal mode: o_fval high for vfront + line_num·line_width + (line_num−1)·hblank + vback cycles.
- Sensor mode: o_fval/o_lval lag i_fval/i_lval by exactly 1 clock.
- ov_test_image_sel changes only on the clock edge where o_fval rises.

## Test plan
- Internal geometry: line_width=4, line_num=3, hblank=2, vfront=1, vback=2, frame_gap=3, stream_en held 1 → o_fval high 19 cycles; three 4-cycle o_lval pulses separated by 2 low cycles; 4 fval-low cycles between frames; o_frame_done once per frame; ov_frame_cnt=1,2,3.
- Pattern change mid-frame: sel_req 000→010 during LINE → ov_test_image_sel stays 000 to end of frame, becomes 010 on the next o_fval rise.
- Stop mid-frame: i_stream_en→0 during HBLANK → frame completes (full 19 cycles), o_frame_done pulses, no further o_fval.
- Sensor mode: i_fval already high when stream_en asserts → no output for that frame. Next sensor frame is reproduced with 1-cycle lag on o_fval/o_lval, and o_lval is masked when i_lval=1 with i_fval=0.
- Zero config: all fields 0 → o_fval high 3 cycles (vfront 1, 1 line of 1, vback 1), o_lval high 1 cycle.
- Reset asserted during LINE → o_fval/o_lval 0 immediately, ov_frame_cnt=0, ov_test_image_sel=000. After release with stream_en=1, a clean frame starts from VFRONT.
